// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Arbiter state encoding and the UART byte width.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } e_arb_state;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above i_ptr,
// wrapping modulo N.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    int j;

    // Walk offsets downward so the smallest offset is the last writer.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (i_req[IW'(j)]) begin
                o_valid = 1'b1;
                o_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_SRC message sources, one message
// per grant, round-robin, with a stall watchdog and release gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 2,
    parameter int IW         = $clog2(N_SRC)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_SRC-1:0]                    i_src_want,
    input  logic [N_SRC-1:0]                    i_src_req,
    input  logic [N_SRC-1:0][UART_BYTE_W-1:0]   i_src_data,
    input  logic [N_SRC-1:0]                    i_src_done,
    output logic [N_SRC-1:0]                    o_src_cts,
    output logic [N_SRC-1:0]                    o_src_idle,
    input  logic                                i_tx_cts,
    input  logic                                i_tx_idle,
    output logic [UART_BYTE_W-1:0]              o_tx_data,
    output logic                                o_tx_req,
    output logic                                o_grant_valid,
    output logic [IW-1:0]                       o_grant_idx,
    output logic                                o_timeout
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_SRC = IW'(N_SRC - 1);

    e_arb_state    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          g_req;
    logic          g_done;
    logic          wd_fire;

    rr_priority_pick #(
        .N  (N_SRC),
        .IW (IW)
    ) u_pick (
        .i_req   (i_src_want),
        .i_ptr   (rr_ptr_q),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    assign o_grant_idx = grant_idx_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        wd_cnt_d      = wd_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        o_src_cts     = '0;
        o_src_idle    = '0;
        o_tx_data     = '0;
        o_tx_req      = 1'b0;
        o_grant_valid = 1'b0;
        o_timeout     = 1'b0;

        g_req   = i_src_req[grant_idx_q];
        g_done  = i_src_done[grant_idx_q];
        wd_fire = (state_q == GRANT) && !g_req && (wd_cnt_q == WD_LAST);

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    wd_cnt_d    = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                o_grant_valid          = 1'b1;
                o_tx_req               = g_req;
                o_tx_data              = i_src_data[grant_idx_q];
                o_src_cts[grant_idx_q]  = i_tx_cts;
                o_src_idle[grant_idx_q] = i_tx_idle;
                // A coincident done wins, so no timeout is reported.
                if (g_done || wd_fire) begin
                    rr_ptr_d  = (grant_idx_q == LAST_SRC) ? '0
                              : grant_idx_q + IW'(1);
                    o_timeout = !g_done;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    wd_cnt_d = g_req ? '0 : wd_cnt_q + WW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            wd_cnt_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            wd_cnt_q    <= wd_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// all checked against a message-level reference model.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int TO   = 16;
    localparam int GAPN = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    i_src_want = '0;
    logic [N-1:0]    i_src_req = '0;
    logic [N-1:0][7:0] i_src_data = '0;
    logic [N-1:0]    i_src_done = '0;
    logic [N-1:0]    o_src_cts;
    logic [N-1:0]    o_src_idle;
    logic            i_tx_cts = 1'b0;
    logic            i_tx_idle = 1'b0;
    logic [7:0]      o_tx_data;
    logic            o_tx_req;
    logic            o_grant_valid;
    logic [1:0]      o_grant_idx;
    logic            o_timeout;

    uart_tx_arbiter #(
        .N_SRC      (N),
        .TIMEOUT    (TO),
        .GAP_CYCLES (GAPN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_src_want    (i_src_want),
        .i_src_req     (i_src_req),
        .i_src_data    (i_src_data),
        .i_src_done    (i_src_done),
        .o_src_cts     (o_src_cts),
        .o_src_idle    (o_src_idle),
        .i_tx_cts      (i_tx_cts),
        .i_tx_idle     (i_tx_idle),
        .o_tx_data     (o_tx_data),
        .o_tx_req      (o_tx_req),
        .o_grant_valid (o_grant_valid),
        .o_grant_idx   (o_grant_idx),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: 0 idle, 1 granted, 2 gap
    int m_st, m_g, m_ptr, m_low, m_gap;
    logic rst_cfg = 1'b0;
    logic s_gv, s_to, s_txreq;
    logic [1:0] s_gidx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        m_st = 0; m_g = 0; m_ptr = 0; m_low = 0; m_gap = 0;
    endtask

    task automatic check_outputs();
        logic       gv;
        logic [3:0] e_cts, e_idle;
        gv     = (m_st == 1);
        e_cts  = (gv && i_tx_cts)  ? (4'b0001 << m_g) : 4'b0000;
        e_idle = (gv && i_tx_idle) ? (4'b0001 << m_g) : 4'b0000;
        chk("grant_valid", o_grant_valid, gv);
        chk("grant_idx", o_grant_idx, m_g);
        chk("tx_req", o_tx_req, gv ? i_src_req[m_g] : 1'b0);
        chk("tx_data", o_tx_data, gv ? i_src_data[m_g] : 8'h00);
        chk("src_cts", o_src_cts, e_cts);
        chk("src_idle", o_src_idle, e_idle);
        chk("timeout", o_timeout,
            gv && !i_src_done[m_g] && !i_src_req[m_g] && (m_low == TO - 1));
    endtask

    task automatic model_update();
        bit found;
        int j;
        case (m_st)
            0: begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && i_src_want[j]) begin
                        found = 1;
                        m_g   = j;
                    end
                end
                if (found) begin
                    m_st  = 1;
                    m_low = 0;
                end
            end
            1: begin
                if (i_src_done[m_g] || (!i_src_req[m_g] && m_low == TO - 1)) begin
                    m_ptr = (m_g + 1) % N;
                    if (GAPN > 0) begin
                        m_st  = 2;
                        m_gap = GAPN;
                    end else begin
                        m_st = 0;
                    end
                end else begin
                    m_low = i_src_req[m_g] ? 0 : m_low + 1;
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_st = 0;
            end
        endcase
    endtask

    task automatic step(input logic [3:0] want, input logic [3:0] req,
                        input logic [3:0] done);
        @(negedge clk);
        rst_n      = rst_cfg;
        i_src_want = want;
        i_src_req  = req;
        i_src_done = done;
        for (int s = 0; s < N; s++) i_src_data[s] = 8'($urandom);
        i_tx_cts  = 1'($urandom);
        i_tx_idle = 1'($urandom);
        #1;
        if (!rst_n) mreset();
        check_outputs();
        s_gv    = o_grant_valid;
        s_gidx  = o_grant_idx;
        s_to    = o_timeout;
        s_txreq = o_tx_req;
        if (rst_n) model_update();
    endtask

    task automatic wait_grant(input logic [3:0] want, input int exp,
                              output int n);
        n = 0;
        do begin
            step(want, 4'b0000, 4'b0000);
            n++;
        end while (!s_gv && n < 10);
        chk("grant_seen", s_gv, 1'b1);
        chk("grant_who", s_gidx, exp);
    endtask

    initial begin
        int n;
        int cnt;
        int exp3[4];
        logic [3:0] b;
        logic [3:0] want_r;
        int p_req;

        mreset();
        exp3 = '{0, 1, 3, 0};

        // reset held with toggling inputs
        rst_cfg = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom));
            chk("rst_gv", s_gv, 1'b0);
            chk("rst_txreq", s_txreq, 1'b0);
        end
        rst_cfg = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b0000, 4'($urandom), 4'($urandom));
        chk("idle_no_want", s_gv, 1'b0);

        // round-robin order with want=1011
        for (int k = 0; k < 4; k++) begin
            wait_grant(4'b1011, exp3[k], n);
            b = 4'b0001 << exp3[k];
            step(4'b1011, b, b);
        end

        // single source message, 3 bytes
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 4'b0000);
        wait_grant(4'b0100, 2, n);
        chk("t2_latency", n, 2);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 4'b0100, 4'b0000);
            chk("t2_txreq", s_txreq, 1'b1);
        end
        step(4'b0000, 4'b0000, 4'b0100);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("t2_gap0", s_gv, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000);
        chk("t2_gap1", s_gv, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000);

        // watchdog on source 1
        wait_grant(4'b0110, 1, n);
        cnt = 1;
        while (!s_to && cnt < 40) begin
            step(4'b0110, 4'b0000, 4'b0000);
            cnt++;
        end
        chk("t4_to_cycle", cnt, 16);
        step(4'b0110, 4'b0000, 4'b0000);
        chk("t4_drop", s_gv, 1'b0);
        wait_grant(4'b0110, 2, n);
        step(4'b0110, 4'b0100, 4'b0100);

        // done coinciding with the watchdog
        wait_grant(4'b0010, 1, n);
        for (int i = 0; i < 14; i++) step(4'b0010, 4'b0000, 4'b0000);
        step(4'b0010, 4'b0000, 4'b0010);
        chk("t5_no_to", s_to, 1'b0);
        chk("t5_gv", s_gv, 1'b1);
        wait_grant(4'b1111, 2, n);
        step(4'b1111, 4'b0100, 4'b0100);

        // asynchronous reset mid-byte
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 4'b0000);
        wait_grant(4'b0001, 0, n);
        step(4'b0001, 4'b0001, 4'b0000);
        chk("t6_pre", s_txreq, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_txreq", o_tx_req, 1'b0);
        chk("t6_gv", o_grant_valid, 1'b0);
        chk("t6_cts", o_src_cts, 4'b0000);
        mreset();
        rst_cfg = 1'b0;
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b1111, 4'b0000);
        rst_cfg = 1'b1;
        wait_grant(4'b1111, 0, n);

        // random traffic
        want_r = 4'($urandom);
        p_req  = 50;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rq, dn;
            if (i % 200 == 0) p_req = (i / 200) % 3 == 0 ? 5
                                    : ((i / 200) % 3 == 1 ? 50 : 90);
            if ($urandom_range(0, 99) < 10) want_r = 4'($urandom);
            for (int s = 0; s < N; s++) rq[s] = ($urandom_range(0, 99) < p_req);
            dn = ($urandom_range(0, 99) < 8) ? 4'($urandom) : 4'b0000;
            step(want_r, rq, dn);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
